// File: rtl/adc_emulator_if.sv
// ---------------------------------------------------------------------------
// adc_emulator_if
// Signal bundle between an ADC controller and the emulated 8-channel
// simultaneous-sampling ADC with dual serial outputs.
//   convst_in      convert start, rising edge starts a conversion
//   os_in          oversampling ratio select (conversion time scale)
//   sclk_in        serial clock from controller, idles high
//   n_cs_in        active-low chip select
//   pattern_en_in  1 = internal counting test pattern, 0 = sample_in
//   sample_in      parallel channel values, channel k at [k*W_DATA +: W_DATA]
//   busy_out       conversion in progress
//   data_a_out     serial line A (channels 0..N_CHAN/2-1)
//   data_b_out     serial line B (channels N_CHAN/2..N_CHAN-1)
//   overrun_out    one-cycle pulse, new data landed over a partly read frame
//   frame_cnt_out  completed conversion count
// slave  = the emulator side, master = the controller side.
// ---------------------------------------------------------------------------
interface adc_emulator_if #(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 8
);
  logic                       convst_in;
  logic [2:0]                 os_in;
  logic                       sclk_in;
  logic                       n_cs_in;
  logic                       pattern_en_in;
  logic [N_CHAN*W_DATA-1:0]   sample_in;
  logic                       busy_out;
  logic                       data_a_out;
  logic                       data_b_out;
  logic                       overrun_out;
  logic [15:0]                frame_cnt_out;

  modport slave (
    input  convst_in, os_in, sclk_in, n_cs_in, pattern_en_in, sample_in,
    output busy_out, data_a_out, data_b_out, overrun_out, frame_cnt_out
  );

  modport master (
    output convst_in, os_in, sclk_in, n_cs_in, pattern_en_in, sample_in,
    input  busy_out, data_a_out, data_b_out, overrun_out, frame_cnt_out
  );
endinterface

// File: rtl/adc_emulator.sv
// ---------------------------------------------------------------------------
// adc_emulator
// Behavioural-but-synthesizable emulation of a simultaneous-sampling ADC with
// a convert-start input, programmable conversion time, and two serial data
// lines read by an external controller (SPI-like, data changes on sclk fall).
// Ports:
//   clk_in    system clock, at least 8x the sclk frequency
//   reset_in  asynchronous active-high reset
//   bus       adc_emulator_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module adc_emulator #(
  parameter int W_DATA      = 18,
  parameter int N_CHAN      = 8,
  parameter int T_CONV_BASE = 40
) (
  input  logic          clk_in,
  input  logic          reset_in,
  adc_emulator_if.slave bus
);

  localparam int HALF   = N_CHAN / 2;
  localparam int LINE_W = HALF * W_DATA;
  localparam int PTR_W  = $clog2(LINE_W + 1);
  localparam int CNT_W  = $clog2((T_CONV_BASE << 6) + 1);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(LINE_W);

  typedef enum logic {IDLE, CONV} state_t;

  // Last value of the down-counter; os=7 is an unsupported ratio and maps to 0.
  function automatic logic [CNT_W-1:0] conv_last(input logic [2:0] os);
    logic [2:0] sh;
    sh = (os == 3'd7) ? 3'd0 : os;
    return CNT_W'((T_CONV_BASE << sh) - 1);
  endfunction

  // Channel word at load time: counting pattern tags each word with the
  // frame number and channel index so a reader can spot slips.
  function automatic logic [W_DATA-1:0] chan_word(
    input int                       k,
    input logic                     pat,
    input logic [14:0]              cnt,
    input logic [N_CHAN*W_DATA-1:0] samples
  );
    logic [17:0] p;
    p = {cnt, 3'(k)};
    if (pat) return W_DATA'(p);
    return samples[k*W_DATA +: W_DATA];
  endfunction

  logic convst_p0, convst_p1, convst_p2, convst_rise_p3;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic n_cs_p0, n_cs_p1, n_cs_p2;
  logic sclk_fall, cs_active;

  state_t           state, state_next;
  logic             conv_start, conv_done;
  logic [CNT_W-1:0] conv_cnt;

  logic [LINE_W-1:0] shift_a, shift_b;
  logic [LINE_W-1:0] load_a, load_b;
  logic [PTR_W-1:0]  ptr;
  logic [15:0]       frame_cnt;
  logic              overrun;

  // ---- stage p0/p1: two-flop synchronizers, p2: edge-detect history ----
  // convst gets one more register so the start pulse lands 3 cycles after
  // the first sampling edge; sclk uses the detector output directly to keep
  // the serial data update inside its 3-cycle window.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      convst_p0      <= 1'b0;
      convst_p1      <= 1'b0;
      convst_p2      <= 1'b0;
      convst_rise_p3 <= 1'b0;
      sclk_p0        <= 1'b0;
      sclk_p1        <= 1'b0;
      sclk_p2        <= 1'b0;
      n_cs_p0        <= 1'b0;
      n_cs_p1        <= 1'b0;
      n_cs_p2        <= 1'b0;
    end else begin
      convst_p0      <= bus.convst_in;
      convst_p1      <= convst_p0;
      convst_p2      <= convst_p1;
      convst_rise_p3 <= convst_p1 & ~convst_p2;
      sclk_p0        <= bus.sclk_in;
      sclk_p1        <= sclk_p0;
      sclk_p2        <= sclk_p1;
      n_cs_p0        <= bus.n_cs_in;
      n_cs_p1        <= n_cs_p0;
      n_cs_p2        <= n_cs_p1;
    end
  end

  assign sclk_fall = sclk_p2 & ~sclk_p1;
  // Chip select must be low across the same sample pair that saw the sclk edge.
  assign cs_active = ~n_cs_p1 & ~n_cs_p2;

  // ---- conversion control ----
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    conv_done  = 1'b0;
    case (state)
      IDLE: if (convst_rise_p3) begin
        state_next = CONV;
        conv_start = 1'b1;
      end
      CONV: if (conv_cnt == '0) begin
        state_next = IDLE;
        conv_done  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)                            conv_cnt <= '0;
    else if (conv_start)                     conv_cnt <= conv_last(bus.os_in);
    else if (state == CONV && conv_cnt != '0) conv_cnt <= conv_cnt - 1'b1;
  end

  // Line A holds ch0 in its top word so channels leave lowest first, MSB first.
  always_comb begin
    load_a = '0;
    load_b = '0;
    for (int k = 0; k < HALF; k++) begin
      load_a[(HALF-1-k)*W_DATA +: W_DATA] =
        chan_word(k, bus.pattern_en_in, frame_cnt[14:0], bus.sample_in);
      load_b[(HALF-1-k)*W_DATA +: W_DATA] =
        chan_word(HALF + k, bus.pattern_en_in, frame_cnt[14:0], bus.sample_in);
    end
  end

  // ---- serial output shifter ----
  // A load always wins over a coincident sclk edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      shift_a   <= '0;
      shift_b   <= '0;
      ptr       <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (conv_done) begin
        shift_a   <= load_a;
        shift_b   <= load_b;
        ptr       <= '0;
        frame_cnt <= frame_cnt + 1'b1;
        overrun   <= (ptr != '0) && (ptr != PTR_END);
      end else if (sclk_fall && cs_active && ptr != PTR_END) begin
        shift_a <= {shift_a[LINE_W-2:0], 1'b0};
        shift_b <= {shift_b[LINE_W-2:0], 1'b0};
        ptr     <= ptr + 1'b1;
      end
    end
  end

  assign bus.busy_out      = (state == CONV);
  assign bus.data_a_out    = shift_a[LINE_W-1] & (ptr != PTR_END);
  assign bus.data_b_out    = shift_b[LINE_W-1] & (ptr != PTR_END);
  assign bus.overrun_out   = overrun;
  assign bus.frame_cnt_out = frame_cnt;

endmodule

// File: tb/tb_adc_emulator.sv
module tb_adc_emulator;
  localparam int W    = 18;
  localparam int N    = 8;
  localparam int HALF = N / 2;
  localparam int LW   = HALF * W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_emulator_if #(.W_DATA(W), .N_CHAN(N)) ifc();

  adc_emulator #(.W_DATA(W), .N_CHAN(N), .T_CONV_BASE(40)) dut (
    .clk_in   (clk),
    .reset_in (reset),
    .bus      (ifc)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int ovr_cnt   = 0;
  int exp_frame = 0;
  logic [W-1:0] ch [N];   // model: channel words that the next/last load carries

  always @(negedge clk) if (ifc.overrun_out === 1'b1) ovr_cnt <= ovr_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: bit i (read order) of a line is channel (line*HALF + i/W),
  // most significant bit first; nothing but zeros after the frame.
  function automatic logic exp_bit(input int line, input int i);
    int c;
    if (i >= LW) return 1'b0;
    c = line * HALF + i / W;
    return ch[c][W-1-(i%W)];
  endfunction

  function automatic logic [LW+7:0] exp_vec(input int line);
    logic [LW+7:0] v;
    v = '0;
    for (int i = 0; i < LW; i++) v[i] = exp_bit(line, i);
    return v;
  endfunction

  function automatic logic [W-1:0] word_at(input logic [LW+7:0] v, input int start);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < W; j++) w = {w[W-2:0], v[start+j]};
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random_samples();
    for (int k = 0; k < N; k++) ch[k] = W'($urandom);
  endtask

  task automatic apply_samples();
    for (int k = 0; k < N; k++) ifc.sample_in[k*W +: W] = ch[k];
  endtask

  // Starts a conversion; rise = cycles from first sampling edge to busy,
  // len = busy high cycles. extra_at > 0 pulses convst again during busy.
  task automatic run_conv(input logic [2:0] os, input int extra_at,
                          output int rise, output int len);
    rise = -1;
    len  = 0;
    ifc.os_in     = os;
    ifc.convst_in = 1'b1;
    for (int c = 1; c <= 12 && rise < 0; c++) begin
      @(posedge clk); #1;
      if (c == 4) ifc.convst_in = 1'b0;
      if (ifc.busy_out === 1'b1) rise = c - 1;
    end
    ifc.convst_in = 1'b0;
    if (rise >= 0) begin
      len = 1;
      while (len < 3000) begin
        if (len == extra_at)     ifc.convst_in = 1'b1;
        if (len == extra_at + 4) ifc.convst_in = 1'b0;
        @(posedge clk); #1;
        if (ifc.busy_out !== 1'b1) break;
        len++;
      end
    end
    ifc.convst_in = 1'b0;
    tick(2);
  endtask

  // Samples both lines before each sclk fall, then clocks one bit.
  task automatic read_bits(input int count, output logic [LW+7:0] a, output logic [LW+7:0] b);
    a = '0;
    b = '0;
    for (int i = 0; i < count; i++) begin
      a[i] = ifc.data_a_out;
      b[i] = ifc.data_b_out;
      ifc.sclk_in = 1'b0;
      tick(8);
      ifc.sclk_in = 1'b1;
      tick(8);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (ifc.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifc.busy_out); end
    n_checks++; if (ifc.data_a_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_a: got %b expected 0", ifc.data_a_out); end
    n_checks++; if (ifc.data_b_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_b: got %b expected 0", ifc.data_b_out); end
    n_checks++; if (ifc.overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ifc.overrun_out); end
    n_checks++; if (ifc.frame_cnt_out !== 16'd0) begin n_fail++; $display("FAIL reset_frame: got %0d expected 0", ifc.frame_cnt_out); end
    reset = 1'b0;
    tick(5);
    n_checks++; if (ifc.busy_out !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b expected 0", ifc.busy_out); end
  endtask

  task automatic test_conv_basic();
    int rise, len;
    random_samples();
    apply_samples();
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    n_checks++; if (rise !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", rise); end
    n_checks++; if (len !== 40) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected 40", len); end
    n_checks++; if (ifc.frame_cnt_out !== 16'(exp_frame)) begin n_fail++; $display("FAIL basic_frame: got %0d expected %0d", ifc.frame_cnt_out, exp_frame); end
    n_checks++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL basic_no_overrun: got %0d expected 0", ovr_cnt); end
  endtask

  task automatic test_oversampling();
    int rise, len, busy_seen;
    run_conv(3'd3, 0, rise, len);
    exp_frame++;
    n_checks++; if (len !== 320) begin n_fail++; $display("FAIL os3_busy_len: got %0d expected 320", len); end
    run_conv(3'd7, 0, rise, len);
    exp_frame++;
    n_checks++; if (len !== 40) begin n_fail++; $display("FAIL os7_busy_len: got %0d expected 40", len); end
    // second pulse mid-conversion, then one whose edge meets the busy fall
    for (int t = 0; t < 2; t++) begin
      run_conv(3'd0, (t == 0) ? 10 : 37, rise, len);
      exp_frame++;
      busy_seen = 0;
      for (int c = 0; c < 60; c++) begin
        tick(1);
        if (ifc.busy_out === 1'b1) busy_seen++;
      end
      n_checks++; if (len !== 40) begin n_fail++; $display("FAIL ignore_busy_len%0d: got %0d expected 40", t, len); end
      n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL ignore_extra_conv%0d: got %0d busy cycles expected 0", t, busy_seen); end
      n_checks++; if (ifc.frame_cnt_out !== 16'(exp_frame)) begin n_fail++; $display("FAIL ignore_frame%0d: got %0d expected %0d", t, ifc.frame_cnt_out, exp_frame); end
    end
  endtask

  task automatic test_read();
    int rise, len;
    logic [LW+7:0] a, b;
    random_samples();
    ch[0] = 18'h2AAAA;
    ch[4] = 18'h15555;
    apply_samples();
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(LW, a, b);
    n_checks++; if (word_at(a, 0) !== 18'h2AAAA) begin n_fail++; $display("FAIL read_ch0: got %h expected 2aaaa", word_at(a, 0)); end
    n_checks++; if (word_at(b, 0) !== 18'h15555) begin n_fail++; $display("FAIL read_ch4: got %h expected 15555", word_at(b, 0)); end
    n_checks++; if (a !== exp_vec(0)) begin n_fail++; $display("FAIL read_line_a: got %h expected %h", a, exp_vec(0)); end
    n_checks++; if (b !== exp_vec(1)) begin n_fail++; $display("FAIL read_line_b: got %h expected %h", b, exp_vec(1)); end
    read_bits(3, a, b);
    n_checks++; if (a[2:0] !== 3'b000 || b[2:0] !== 3'b000) begin n_fail++; $display("FAIL read_tail_zero: got a=%b b=%b expected 000", a[2:0], b[2:0]); end
    ifc.n_cs_in = 1'b1;
    tick(4);
  endtask

  task automatic test_pattern();
    int rise, len;
    logic [LW+7:0] a, b;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    exp_frame = 0;
    ifc.pattern_en_in = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) ch[k] = {exp_frame[14:0], 3'(k)};
      run_conv(3'd0, 0, rise, len);
      exp_frame++;
    end
    n_checks++; if (ifc.frame_cnt_out !== 16'd3) begin n_fail++; $display("FAIL pattern_frame: got %0d expected 3", ifc.frame_cnt_out); end
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(LW, a, b);
    n_checks++; if (word_at(b, W) !== 18'h00015) begin n_fail++; $display("FAIL pattern_ch5: got %h expected 00015", word_at(b, W)); end
    n_checks++; if (a !== exp_vec(0)) begin n_fail++; $display("FAIL pattern_line_a: got %h expected %h", a, exp_vec(0)); end
    n_checks++; if (b !== exp_vec(1)) begin n_fail++; $display("FAIL pattern_line_b: got %h expected %h", b, exp_vec(1)); end
    ifc.pattern_en_in = 1'b0;
    ifc.n_cs_in = 1'b1;
    tick(4);
  endtask

  task automatic test_cs_pause();
    int rise, len, ovr0;
    logic [LW+7:0] a1, b1, a2, b2, ad, bd, a, b;
    ovr0 = ovr_cnt;
    random_samples();
    apply_samples();
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(10, a1, b1);
    ifc.n_cs_in = 1'b1;
    tick(4);
    read_bits(5, ad, bd);
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(LW - 10, a2, b2);
    a = a1 | (a2 << 10);
    b = b1 | (b2 << 10);
    n_checks++; if (ad[4:0] !== {5{exp_bit(0, 10)}}) begin n_fail++; $display("FAIL cs_hold_line: got %b expected %b", ad[4:0], {5{exp_bit(0, 10)}}); end
    n_checks++; if (a2[0] !== exp_bit(0, 10) || b2[0] !== exp_bit(1, 10)) begin n_fail++; $display("FAIL cs_resume_bit: got a=%b b=%b expected a=%b b=%b", a2[0], b2[0], exp_bit(0, 10), exp_bit(1, 10)); end
    n_checks++; if (a !== exp_vec(0)) begin n_fail++; $display("FAIL cs_line_a: got %h expected %h", a, exp_vec(0)); end
    n_checks++; if (b !== exp_vec(1)) begin n_fail++; $display("FAIL cs_line_b: got %h expected %h", b, exp_vec(1)); end
    n_checks++; if (ovr_cnt !== ovr0) begin n_fail++; $display("FAIL cs_no_overrun: got %0d expected %0d", ovr_cnt, ovr0); end
    ifc.n_cs_in = 1'b1;
    tick(4);
  endtask

  task automatic test_overrun();
    int rise, len, ovr0;
    logic [LW+7:0] a, b;
    random_samples();
    apply_samples();
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    ovr0 = ovr_cnt;
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(30, a, b);
    random_samples();
    apply_samples();
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    n_checks++; if (ovr_cnt - ovr0 !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt - ovr0); end
    n_checks++; if (ifc.frame_cnt_out !== 16'(exp_frame)) begin n_fail++; $display("FAIL overrun_frame: got %0d expected %0d", ifc.frame_cnt_out, exp_frame); end
    read_bits(LW, a, b);
    n_checks++; if (a !== exp_vec(0)) begin n_fail++; $display("FAIL overrun_reload_a: got %h expected %h", a, exp_vec(0)); end
    n_checks++; if (b !== exp_vec(1)) begin n_fail++; $display("FAIL overrun_reload_b: got %h expected %h", b, exp_vec(1)); end
    ovr0 = ovr_cnt;
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    n_checks++; if (ovr_cnt !== ovr0) begin n_fail++; $display("FAIL overrun_full_read: got %0d expected %0d", ovr_cnt, ovr0); end
  endtask

  task automatic test_reset_mid();
    int rise, len, ovr0, busy_seen;
    logic [LW+7:0] a, b;
    ifc.n_cs_in = 1'b0;
    tick(4);
    read_bits(20, a, b);
    ifc.convst_in = 1'b1;
    tick(4);
    ifc.convst_in = 1'b0;
    tick(10);
    n_checks++; if (ifc.busy_out !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", ifc.busy_out); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (ifc.busy_out !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", ifc.busy_out); end
    n_checks++; if (ifc.frame_cnt_out !== 16'd0) begin n_fail++; $display("FAIL rmid_frame: got %0d expected 0", ifc.frame_cnt_out); end
    n_checks++; if (ifc.data_a_out !== 1'b0 || ifc.data_b_out !== 1'b0) begin n_fail++; $display("FAIL rmid_data: got a=%b b=%b expected 0", ifc.data_a_out, ifc.data_b_out); end
    tick(3);
    ovr0 = ovr_cnt;
    reset = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (ifc.busy_out === 1'b1) busy_seen++;
    end
    n_checks++; if (busy_seen !== 0 || ifc.frame_cnt_out !== 16'd0) begin n_fail++; $display("FAIL rmid_abort: got busy=%0d frame=%0d expected 0 0", busy_seen, ifc.frame_cnt_out); end
    ifc.n_cs_in = 1'b1;
    exp_frame = 0;
    run_conv(3'd0, 0, rise, len);
    exp_frame++;
    n_checks++; if (rise !== 3) begin n_fail++; $display("FAIL rmid_latency: got %0d expected 3", rise); end
    n_checks++; if (len !== 40) begin n_fail++; $display("FAIL rmid_busy_len: got %0d expected 40", len); end
    n_checks++; if (ifc.frame_cnt_out !== 16'(exp_frame)) begin n_fail++; $display("FAIL rmid_frame_after: got %0d expected %0d", ifc.frame_cnt_out, exp_frame); end
    n_checks++; if (ovr_cnt !== ovr0) begin n_fail++; $display("FAIL rmid_no_overrun: got %0d expected %0d", ovr_cnt, ovr0); end
  endtask

  initial begin
    ifc.convst_in     = 1'b0;
    ifc.os_in         = 3'd0;
    ifc.sclk_in       = 1'b1;
    ifc.n_cs_in       = 1'b1;
    ifc.pattern_en_in = 1'b0;
    ifc.sample_in     = '0;
    reset = 1'b1;
    tick(3);
    test_reset();
    test_conv_basic();
    test_oversampling();
    test_read();
    test_pattern();
    test_cs_pause();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_emulator.md
ADC_EMULATOR -- requirements
Module: adc_emulator

Interface
REQ-001 SHALL have parameter W_DATA, default 18, bits per channel sample.
REQ-002 SHALL have parameter N_CHAN, default 8, channels per conversion (even; N_CHAN/2 per serial line).
REQ-003 SHALL have parameter T_CONV_BASE, default 40, conversion time in clk_in cycles at os=0.
REQ-004 SHALL have port clk_in  input  1  system clock; the clock is clk_in and SHALL be at least 8x the sclk_in frequency.
REQ-005 SHALL have port reset_in  input  1  reset; the reset is reset_in, asynchronous, active-high.
REQ-006 SHALL have port convst_in  input  1  convert start (asynchronous); a rising edge starts a conversion.
REQ-007 SHALL have port os_in  input  3  oversampling mode, sampled at conversion start.
REQ-008 SHALL have port sclk_in  input  1  serial clock from controller (asynchronous, idles high).
REQ-009 SHALL have port n_cs_in  input  1  active-low chip select (asynchronous).
REQ-010 SHALL have port pattern_en_in  input  1  1 = internal test pattern, 0 = sample_in.
REQ-011 SHALL have port sample_in  input  N_CHAN*W_DATA  parallel channel values; channel k occupies bits [k*W_DATA +: W_DATA].
REQ-012 SHALL have port busy_out  output  1  conversion in progress.
REQ-013 SHALL have port data_a_out  output  1  serial data, channels 0..N_CHAN/2-1.
REQ-014 SHALL have port data_b_out  output  1  serial data, channels N_CHAN/2..N_CHAN-1.
REQ-015 SHALL have port overrun_out  output  1  one-cycle pulse: new data latched while a frame was partly read.
REQ-016 SHALL have port frame_cnt_out  output  16  count of completed conversions.

Function
REQ-017 SHALL pass convst_in, sclk_in, n_cs_in each through a 2-flop synchronizer, followed by a registered edge detector.
REQ-018 SHALL implement the conversion FSM with states IDLE and CONV; IDLE->CONV on a synchronized convst_in rising edge; CONV->IDLE when the conversion counter expires.
REQ-019 SHALL assert busy_out exactly 3 clk_in cycles after the first clk_in edge that samples convst_in high, and hold it for the conversion time.
REQ-020 SHALL set the conversion time to T_CONV_BASE << os_lat cycles; os_lat is os_in latched at the IDLE->CONV transition; os_in of 7 is treated as 0.
REQ-021 SHALL ignore convst_in rising edges while in CONV, including an edge detected in the same cycle busy_out falls.
REQ-022 SHALL, on the cycle busy_out falls, load the per-line shift registers (length N_CHAN/2*W_DATA) as follows: line A = ch0..ch(N/2-1), line B = ch(N/2)..ch(N-1), each MSB first, lowest channel first.
REQ-023 SHALL, on the same busy_out falling cycle, reset the bit pointer to 0 and increment frame_cnt_out (wraps 0xFFFF->0).
REQ-024 SHALL, when pattern_en_in=1, form channel k as {frame_cnt_out[14:0] (pre-increment value), k[2:0]}; otherwise channel k SHALL be sample_in[k], captured at load.
REQ-025 SHALL drive data_a_out/data_b_out from the shift-register MSBs at all times (not gated by n_cs_in), so the first bit is valid before the first sclk edge.
REQ-026 SHALL, on each synchronized sclk_in falling edge while synchronized n_cs_in=0, shift each register left with 0 fill and increment the bit pointer, saturating at N_CHAN/2*W_DATA.
REQ-027 SHALL drive the new bit on the data outputs within 3 clk_in cycles of the sclk_in falling edge.
REQ-028 SHALL output 0 on both lines once the bit pointer reaches N_CHAN/2*W_DATA, until the next load.
REQ-029 SHALL hold the bit pointer and the shift contents while n_cs_in=1 (mid-frame deassert); the read resumes from the held bit when n_cs_in returns to 0.
REQ-030 SHALL pulse overrun_out for 1 cycle when a load occurs with the bit pointer strictly between 0 and N_CHAN/2*W_DATA; the load still occurs.
REQ-031 SHALL allow a read during CONV; the data shifted out is from the previous conversion.

Reset
REQ-032 SHALL, while reset_in=1, force the following asynchronously: busy_out=0, data_a_out=0, data_b_out=0, overrun_out=0, frame_cnt_out=0, FSM=IDLE, counters, pointer, shift registers and synchronizers all 0.
REQ-033 SHALL, if reset_in is asserted mid-conversion or mid-frame, abort the operation with no load and no overrun; the first convst_in edge after release starts a fresh conversion.

Verification
REQ-034 SHALL cover: os_in=0, one convst_in pulse -> busy_out rises 3 cycles later and stays high exactly 40 cycles; frame_cnt_out goes 0->1.
REQ-035 SHALL cover: os_in=3 -> busy_out high 320 cycles; os_in=7 -> busy_out high 40 cycles; a second convst_in pulse during busy_out -> no extra conversion.
REQ-036 SHALL cover: sample_in ch0=0x2AAAA, ch4=0x15555, full 72-sclk read -> line A first 18 bits 0x2AAAA, line B first 18 bits 0x15555, both lines 0 after bit 72.
REQ-037 SHALL cover: pattern_en_in=1, third conversion -> channel 5 reads {15'd2, 3'd5} = 0x00015.
REQ-038 SHALL cover: n_cs_in deasserted after 10 bits, then reasserted -> bit 11 continues correctly; a new conversion ending at pointer=30 -> overrun_out pulses once and the pointer returns to 0.
REQ-039 SHALL cover: reset_in asserted mid-CONV -> busy_out=0 immediately, frame_cnt_out=0, next conversion behaves per REQ-034.
